// File: rtl/rp_led_isolator.sv
// Output isolator for the DFX LED partitions: freezes the LED pins during reconfiguration and flags stalled RM bits.
// Optional build macro ISO_FORCE_OFF_EN drives the pins low while isolated instead of holding them.
module rp_led_isolator #(
  parameter int unsigned N_LED      = 2,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned STALL_CYC  = 100_000_000
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic [N_LED-1:0] leds_rp_i,
  input  logic             decouple_req_i,
  output logic             decouple_ack_o,
  output logic [N_LED-1:0] leds_o,
  output logic [N_LED-1:0] rp_stall_o
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
  localparam int unsigned SW_RAW     = $clog2(SETTLE_CYC + 1);
  localparam int unsigned SW         = (SW_RAW < 1) ? 1 : SW_RAW;
  localparam int unsigned STW_RAW    = $clog2(STALL_CYC + 1);
  localparam int unsigned STW        = (STW_RAW < 1) ? 1 : STW_RAW;

  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_EFF - 1);
  localparam logic [STW-1:0] STALL_MAX   = STW'(STALL_CYC);

  typedef enum logic [1:0] {
    PASS,
    HOLD,
    SETTLE
  } state_t;

  state_t           state;
  logic [N_LED-1:0] leds_q;
  logic [N_LED-1:0] leds_prev;
  logic [SW-1:0]    settle_cnt;
  logic [STW-1:0]   stall_cnt     [N_LED];
  logic [STW-1:0]   stall_cnt_nxt [N_LED];
  logic [N_LED-1:0] toggle;

  assign toggle = leds_q ^ leds_prev;

  // Ack is registered from the current state, so it lags state by one edge.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state          <= PASS;
      leds_q         <= '0;
      leds_prev      <= '0;
      leds_o         <= '0;
      decouple_ack_o <= 1'b0;
      settle_cnt     <= '0;
    end else begin
      leds_q         <= leds_rp_i;
      leds_prev      <= leds_q;
      decouple_ack_o <= (state != PASS);
      case (state)
        PASS: begin
          leds_o <= leds_q;
          if (decouple_req_i) state <= HOLD;
        end
        HOLD: begin
`ifdef ISO_FORCE_OFF_EN
          leds_o <= '0;
`else
          leds_o <= leds_o;
`endif
          if (!decouple_req_i) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
`ifdef ISO_FORCE_OFF_EN
          leds_o <= '0;
`else
          leds_o <= leds_o;
`endif
          if (decouple_req_i) begin
            state <= HOLD;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= PASS;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  // Stall flag is derived from the next count so it tracks the counter without an extra lag.
  always_comb begin
    for (int unsigned i = 0; i < N_LED; i++) begin
      stall_cnt_nxt[i] = '0;
      if (state == PASS && !toggle[i]) begin
        if (stall_cnt[i] == STALL_MAX) stall_cnt_nxt[i] = stall_cnt[i];
        else                           stall_cnt_nxt[i] = stall_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      rp_stall_o <= '0;
      for (int unsigned i = 0; i < N_LED; i++) stall_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_LED; i++) begin
        stall_cnt[i]  <= stall_cnt_nxt[i];
        rp_stall_o[i] <= (state == PASS) && (stall_cnt_nxt[i] == STALL_MAX);
      end
    end
  end

endmodule

// File: tb/tb_rp_led_isolator.sv
// Directed bench for rp_led_isolator: reset, latency, decouple handshake, settle restart, stall monitor, mid-settle reset.
module tb_rp_led_isolator;

  logic       clk100;
  logic       rst;
  logic [1:0] leds_rp_i;
  logic       decouple_req_i;
  logic       decouple_ack_o;
  logic [1:0] leds_o;
  logic [1:0] rp_stall_o;

  int checks = 0;
  int errors = 0;

`ifdef ISO_FORCE_OFF_EN
  localparam logic [1:0] FRZ_A = 2'b00;
  localparam logic [1:0] FRZ_B = 2'b00;
`else
  localparam logic [1:0] FRZ_A = 2'b10;
  localparam logic [1:0] FRZ_B = 2'b01;
`endif

  rp_led_isolator #(
    .N_LED      (2),
    .SETTLE_CYC (16),
    .STALL_CYC  (1000)
  ) dut (
    .clk100         (clk100),
    .rst            (rst),
    .leds_rp_i      (leds_rp_i),
    .decouple_req_i (decouple_req_i),
    .decouple_ack_o (decouple_ack_o),
    .leds_o         (leds_o),
    .rp_stall_o     (rp_stall_o)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;

    // reset dominates all inputs
    rst = 1'b1; leds_rp_i = 2'b11; decouple_req_i = 1'b1;
    repeat (3) step();
    check("rst_leds", int'(leds_o), 'b00);
    check("rst_ack", int'(decouple_ack_o), 0);
    check("rst_stall", int'(rp_stall_o), 'b00);
    leds_rp_i = 2'b00; decouple_req_i = 1'b0; rst = 1'b0;
    repeat (3) step();
    check("pass_ack", int'(decouple_ack_o), 0);

    // two-cycle input-to-pin latency
    leds_rp_i = 2'b01;
    step();
    check("lat_edge1", int'(leds_o), 'b00);
    step();
    check("lat_edge2", int'(leds_o), 'b01);
    check("lat_ack", int'(decouple_ack_o), 0);

    // decouple with garbage inputs
    leds_rp_i = 2'b10;
    repeat (2) step();
    check("pre_hold_leds", int'(leds_o), 'b10);
    decouple_req_i = 1'b1;
    step();
    check("req_edge_ack", int'(decouple_ack_o), 0);
    check("req_edge_leds", int'(leds_o), 'b10);
    step();
    check("ack_rise", int'(decouple_ack_o), 1);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      leds_rp_i = 2'($urandom_range(0, 3));
      step();
      if (leds_o !== FRZ_A || decouple_ack_o !== 1'b1) bad = 1'b1;
    end
    check("hold_frozen", int'(bad), 0);

    // release: ack stays up through the 16-cycle settle window
    leds_rp_i = 2'b01; decouple_req_i = 1'b0;
    step();
    check("rel_edge_ack", int'(decouple_ack_o), 1);
    bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (decouple_ack_o !== 1'b1 || leds_o !== FRZ_A) bad = 1'b1;
    end
    check("settle_hold", int'(bad), 0);
    step();
    check("settle_ack_drop", int'(decouple_ack_o), 0);
    check("resume_leds", int'(leds_o), 'b01);

    // re-request at settle cycle 8 restarts the full window
    decouple_req_i = 1'b1;
    repeat (2) step();
    check("t4_ack", int'(decouple_ack_o), 1);
    repeat (3) step();
    decouple_req_i = 1'b0;
    step();
    bad = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (decouple_ack_o !== 1'b1) bad = 1'b1;
    end
    decouple_req_i = 1'b1;
    repeat (5) step();
    if (decouple_ack_o !== 1'b1) bad = 1'b1;
    check("t4_no_drop", int'(bad), 0);
    check("t4_leds", int'(leds_o), int'(FRZ_B));
    decouple_req_i = 1'b0;
    step();
    n = 0;
    while (decouple_ack_o === 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("t4_settle_len", n, 17);

    // reset while in SETTLE with req re-asserted
    decouple_req_i = 1'b1;
    repeat (3) step();
    decouple_req_i = 1'b0;
    repeat (4) step();
    check("t6_pre_leds", int'(leds_o), int'(FRZ_B));
    check("t6_pre_ack", int'(decouple_ack_o), 1);
    decouple_req_i = 1'b1;
    rst = 1'b1;
    #1;
    check("t6_async_ack", int'(decouple_ack_o), 0);
    check("t6_async_leds", int'(leds_o), 'b00);
    step();
    rst = 1'b0;
    step();
    check("t6_edge1_ack", int'(decouple_ack_o), 0);
    step();
    check("t6_edge2_ack", int'(decouple_ack_o), 1);

    // stall monitor: bit0 idle, bit1 toggling every 100 cycles
    rst = 1'b1; decouple_req_i = 1'b0; leds_rp_i = 2'b00;
    step();
    rst = 1'b0;
    for (int j = 1; j <= 1200; j++) begin
      leds_rp_i[1] = ((j / 100) % 2) == 1;
      step();
      if (j == 999)  check("stall_before", int'(rp_stall_o), 'b00);
      if (j == 1000) check("stall_set", int'(rp_stall_o), 'b01);
      if (j == 1200) check("stall_sat", int'(rp_stall_o), 'b01);
    end
    leds_rp_i[0] = 1'b1;
    step();
    check("stall_pre_toggle", int'(rp_stall_o), 'b01);
    step();
    check("stall_clear", int'(rp_stall_o), 'b00);
    decouple_req_i = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rp_stall_o !== 2'b00) bad = 1'b1;
    end
    check("stall_hold_zero", int'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
